// File: rtl/pixel_write_buffer_pkg.sv
// ------------------------------------------------------------------
// pixel_write_buffer_pkg : screen defaults, pixel entry and FSM types
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package pixel_write_buffer_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int COLOUR_W_DEF = 3;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
  } pixel_pos_t;

  // FIFO entry layout; the top packs the same order with its own colour width
  typedef struct packed {
    pixel_pos_t                pos;
    logic [COLOUR_W_DEF-1:0]   colour;
  } pixel_entry_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } wr_state_e;

  function automatic logic in_screen(input logic [7:0] x, input logic [6:0] y,
                                     input int w, input int h);
    return (int'(x) < w) && (int'(y) < h);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_fifo.sv
// ------------------------------------------------------------------
// pixel_fifo : synchronous FIFO with first-word-fall-through read port
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module pixel_fifo #(
  parameter  int WIDTH = 18,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop frees the slot in the same cycle, so push-on-full is legal with it
  assign w_do_pop  = pop_i & ~empty_o;
  assign w_do_push = push_i & (~full_o | w_do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/pixel_write_buffer.sv
// ------------------------------------------------------------------
// pixel_write_buffer : clips, queues and drains drawer pixels to the framebuffer
// Rev 1.0   optional: PIXEL_DEDUP_EN drops repeats of the last pushed pixel
// ------------------------------------------------------------------
`default_nettype none

module pixel_write_buffer
  import pixel_write_buffer_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int DEPTH    = 16,
  parameter int COLOUR_W = COLOUR_W_DEF,
  parameter int ADDR_W   = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                plot_in,
  input  logic [7:0]          x_in,
  input  logic [6:0]          y_in,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic                done_in,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [COLOUR_W-1:0] mem_data,
  output logic                busy,
  output logic                overflow,
  output logic [7:0]          clip_count,
  output logic                frame_done
);

  localparam int ENTRY_W = $bits(pixel_pos_t) + COLOUR_W;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  pixel_pos_t          w_in_pos;
  pixel_pos_t          w_head_pos;
  logic [COLOUR_W-1:0] w_head_colour;
  logic [ENTRY_W-1:0]  w_head;
  logic                w_full, w_empty;
  logic [CNT_W-1:0]    w_count;
  logic                w_in_range, w_dup, w_accept, w_push, w_pop;

  wr_state_e           state_q, state_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [COLOUR_W-1:0] mem_data_q, mem_data_d;
  logic                overflow_q, overflow_d;
  logic [7:0]          clip_q, clip_d;
  logic                done_prev_q, done_pend_q, done_pend_d;

  assign w_in_pos   = {x_in, y_in};
  assign w_in_range = in_screen(x_in, y_in, SCREEN_W, SCREEN_H);

`ifdef PIXEL_DEDUP_EN
  pixel_pos_t last_pos_q;
  logic       last_vld_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_vld_q <= 1'b0;
      last_pos_q <= '0;
    end else if (frame_done) begin
      last_vld_q <= 1'b0;
    end else if (w_push) begin
      last_vld_q <= 1'b1;
      last_pos_q <= w_in_pos;
    end
  end

  assign w_dup = last_vld_q && (last_pos_q == w_in_pos);
`else
  assign w_dup = 1'b0;
`endif

  assign w_accept = plot_in & w_in_range & ~w_dup;
  assign w_push   = w_accept & (~w_full | w_pop);

  pixel_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  ({w_in_pos, colour_in}),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  assign {w_head_pos, w_head_colour} = w_head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!w_empty)              state_d = ST_WRITE;
      ST_WRITE: if (mem_ready && w_empty)  state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  // mem_we is exactly the WRITE state; the address/data register loads on every pop
  always_comb begin
    mem_we     = (state_q == ST_WRITE);
    w_pop      = !w_empty && ((state_q == ST_IDLE) || mem_ready);
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    if (w_pop) begin
      mem_addr_d = ADDR_W'(int'(w_head_pos.y) * SCREEN_W + int'(w_head_pos.x));
      mem_data_d = w_head_colour;
    end
  end

  assign overflow_d  = overflow_q | (w_accept & w_full & ~w_pop);
  assign clip_d      = (plot_in && !w_in_range && clip_q != 8'hFF) ? clip_q + 8'd1 : clip_q;
  assign frame_done  = done_pend_q & w_empty & ~mem_we & ~plot_in;
  assign done_pend_d = (done_in & ~done_prev_q) | (done_pend_q & ~frame_done);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      overflow_q  <= 1'b0;
      clip_q      <= '0;
      done_prev_q <= 1'b0;
      done_pend_q <= 1'b0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      overflow_q  <= overflow_d;
      clip_q      <= clip_d;
      done_prev_q <= done_in;
      done_pend_q <= done_pend_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign overflow   = overflow_q;
  assign clip_count = clip_q;
  assign busy       = (w_count != '0) | mem_we;

endmodule

`default_nettype wire

// File: tb/tb_pixel_write_buffer.sv
// ------------------------------------------------------------------
// tb_pixel_write_buffer : queue-based reference model plus directed vectors
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_pixel_write_buffer;

  localparam int SW = 160;
  localparam int SH = 120;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        plot_in = 1'b0;
  logic [7:0]  x_in = '0;
  logic [6:0]  y_in = '0;
  logic [2:0]  colour_in = '0;
  logic        done_in = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        busy, overflow, frame_done;
  logic [7:0]  clip_count;

  pixel_write_buffer dut (
    .clk(clk), .rst(rst), .plot_in(plot_in), .x_in(x_in), .y_in(y_in),
    .colour_in(colour_in), .done_in(done_in), .mem_ready(mem_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy),
    .overflow(overflow), .clip_count(clip_count), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 0;

  // Reference model: pixels waiting, plus the one being presented to memory
  typedef struct { int x; int y; int c; } pix_t;
  pix_t m_fifo[$];
  pix_t m_out;
  bit   m_out_vld = 0, m_ovf = 0, m_pend = 0, m_done_prev = 0, m_last_vld = 0;
  int   m_clip = 0, m_lx = 0, m_ly = 0;

  int   w_addr[$];
  int   w_data[$];
  int   last_hs = -1, fd_cnt = 0, fd_cyc = -1;

  function automatic bit m_frame_done();
    return m_pend && (m_fifo.size() == 0) && !m_out_vld && !plot_in;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_fifo.delete();
      m_out_vld = 0; m_ovf = 0; m_clip = 0; m_pend = 0; m_done_prev = 0; m_last_vld = 0;
    end else begin
      bit fd, pop, inr, dup, room;
      fd   = m_frame_done();
      pop  = (m_fifo.size() > 0) && (!m_out_vld || mem_ready);
      room = (m_fifo.size() < DEPTH) || pop;
      inr  = plot_in && (int'(x_in) < SW) && (int'(y_in) < SH);
      dup  = 0;
`ifdef PIXEL_DEDUP_EN
      dup  = m_last_vld && (m_lx == int'(x_in)) && (m_ly == int'(y_in));
`endif
      if (plot_in && !inr && m_clip < 255) m_clip++;
      if (pop) begin
        m_out = m_fifo.pop_front();
        m_out_vld = 1;
      end else if (m_out_vld && mem_ready) begin
        m_out_vld = 0;
      end
      if (inr && !dup) begin
        if (room) begin
          m_fifo.push_back('{int'(x_in), int'(y_in), int'(colour_in)});
          m_last_vld = 1; m_lx = int'(x_in); m_ly = int'(y_in);
        end else begin
          m_ovf = 1;
        end
      end
      if (fd) m_last_vld = 0;
      m_pend = (done_in && !m_done_prev) || (m_pend && !fd);
      m_done_prev = done_in;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit ok, e_busy;
      int e_addr;
      e_addr = m_out.y * SW + m_out.x;
      e_busy = (m_fifo.size() != 0) || m_out_vld;
      ok = (mem_we === m_out_vld) &&
           (!m_out_vld || (mem_addr === 15'(e_addr) && mem_data === 3'(m_out.c))) &&
           (busy === e_busy) && (overflow === m_ovf) &&
           (clip_count === 8'(m_clip)) && (frame_done === m_frame_done());
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL cycle_model cyc=%0d we=%b/%b addr=%0d/%0d data=%0d/%0d busy=%b/%b ovf=%b/%b clip=%0d/%0d fd=%b/%b (actual/required)",
                 cyc, mem_we, m_out_vld, mem_addr, e_addr, mem_data, m_out.c, busy, e_busy,
                 overflow, m_ovf, clip_count, m_clip, frame_done, m_frame_done());
      end
      if (mem_we && mem_ready) begin
        w_addr.push_back(int'(mem_addr));
        w_data.push_back(int'(mem_data));
        last_hs = cyc;
      end
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic plot(input int x, input int y, input int c);
    plot_in = 1'b1; x_in = 8'(x); y_in = 7'(y); colour_in = 3'(c);
    tick();
    plot_in = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (busy && n < maxc) begin
      tick();
      n++;
    end
    check("wait_idle_in_budget", int'(n < maxc), 1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, fd0;
    int bx[8] = '{81, 83, 79, 77, 81, 83, 79, 77};
    int by[8] = '{63, 61, 63, 61, 57, 59, 57, 59};
    int ba[8] = '{10161, 9843, 10159, 9837, 9201, 9523, 9199, 9517};

    #2 rst = 1'b0;
    #1 chk_en = 1;
    check("reset_mem_we", int'(mem_we), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_addr", int'(mem_addr), 0);
    check("reset_clip", int'(clip_count), 0);
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // single pixel
    mem_ready = 1'b1;
    base = w_addr.size();
    plot(10, 5, 3);
    wait_idle(20);
    check("single_writes", w_addr.size() - base, 1);
    check("single_addr", w_addr[base], 810);
    check("single_data", w_data[base], 3);
    check("single_overflow", int'(overflow), 0);

    // 8-pixel burst against a 20-cycle stall
    mem_ready = 1'b0;
    base = w_addr.size();
    for (int i = 0; i < 8; i++) plot(bx[i], by[i], i);
    repeat (12) tick();
    mem_ready = 1'b1;
    wait_idle(40);
    check("burst_writes", w_addr.size() - base, 8);
    for (int i = 0; i < 8; i++) begin
      check("burst_addr", w_addr[base + i], ba[i]);
      check("burst_data", w_data[base + i], i);
    end

    // clipping and saturation
    base = w_addr.size();
    plot(200, 5, 1);
    plot(5, 120, 1);
    tick();
    check("clip_two", int'(clip_count), 2);
    check("clip_no_write", w_addr.size() - base, 0);
    for (int i = 0; i < 300; i++) plot(200 + (i % 50), 5, 1);
    tick();
    check("clip_saturate", int'(clip_count), 255);

    // overflow with memory stalled
    mem_ready = 1'b0;
    base = w_addr.size();
    for (int i = 0; i < 20; i++) plot(i, 10, i);
    tick();
    check("ovf_set", int'(overflow), 1);
    mem_ready = 1'b1;
    wait_idle(60);
    check("ovf_writes", w_addr.size() - base, 17);
    check("ovf_first_addr", w_addr[base], 1600);
    check("ovf_last_addr", w_addr[base + 16], 1616);

    // frame done after pending pixels drain
    mem_ready = 1'b0;
    fd0 = fd_cnt;
    base = w_addr.size();
    for (int i = 0; i < 5; i++) plot(20 + i, 30, 2);
    done_in = 1'b1;
    repeat (6) tick();
    check("fd_not_early", fd_cnt - fd0, 0);
    mem_ready = 1'b1;
    wait_idle(40);
    repeat (3) tick();
    check("fd_writes", w_addr.size() - base, 5);
    check("fd_pulses", fd_cnt - fd0, 1);
    check("fd_timing", fd_cyc, last_hs + 1);
    done_in = 1'b0;
    tick();

    // duplicate suppression
    base = w_addr.size();
    plot(3, 4, 1);
    plot(3, 4, 1);
    plot(4, 4, 1);
    wait_idle(20);
`ifdef PIXEL_DEDUP_EN
    check("dedup_writes", w_addr.size() - base, 2);
`else
    check("dedup_writes", w_addr.size() - base, 3);
`endif

    // reset in the middle of a burst
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) plot(50 + i, 50, 5);
    plot_in = 1'b1; x_in = 8'd60; y_in = 7'd50;
    rst = 1'b0;
    #1;
    check("rst_mid_we", int'(mem_we), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_ovf", int'(overflow), 0);
    check("rst_mid_clip", int'(clip_count), 0);
    check("rst_mid_addr", int'(mem_addr), 0);
    plot_in = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    mem_ready = 1'b1;
    base = w_addr.size();
    repeat (10) tick();
    check("rst_no_writes", w_addr.size() - base, 0);
    check("rst_idle", int'(busy), 0);

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
